fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h8000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries, also the maximum number of requests in flight; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-005 redirect_valid  input  1  flush and restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-007 mem_req_valid  output  1  fetch request valid.
REQ-008 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 mem_req_addr  output  32  word-aligned fetch address.
REQ-010 mem_resp_valid  input  1  read data returned, in request order, one per accepted request, at least 1 cycle after acceptance.
REQ-011 mem_resp_data  input  32  returned instruction word.
REQ-012 instr_valid  output  1  buffer head holds an instruction.
REQ-013 instr_ready  input  1  decode stage consumes the head this cycle.
REQ-014 instr  output  32  head instruction word.
REQ-015 instr_pc  output  32  address the head instruction was fetched from.

Function
REQ-016 The block SHALL keep fetch_pc, fetch_pc SHALL drive mem_req_addr, and fetch_pc SHALL advance by 4 on each accepted request (mem_req_valid & mem_req_ready), wrapping modulo 2^32.
REQ-017 mem_req_valid SHALL be the combinational result (buf_count + outstanding < DEPTH) & !redirect_valid, using the registered counts only, with no same-cycle pop or response credit.
REQ-018 outstanding SHALL count accepted requests whose responses have not yet returned: +1 on accept, -1 on mem_resp_valid, and both in the same cycle SHALL leave it unchanged.
REQ-019 drop_count SHALL count in-flight responses that are stale; while drop_count > 0, each mem_resp_valid SHALL be discarded and SHALL decrement drop_count.
REQ-020 While drop_count == 0 and redirect_valid is low, mem_resp_valid SHALL push {fetch address, data} into the buffer.
REQ-021 The buffer SHALL be an in-order FIFO; instr, instr_pc and instr_valid SHALL come from registered head state, giving a minimum latency of 1 cycle from mem_resp_valid to instr_valid.
REQ-022 A pop SHALL occur on instr_valid & instr_ready, and a push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-023 The credit rule SHALL make buffer overflow impossible; a push into a full buffer is a design error, flagged by an assertion.
REQ-024 On redirect_valid, the buffer SHALL empty, and any pop in that cycle SHALL be ignored.
REQ-025 On redirect_valid, fetch_pc SHALL load {redirect_pc[31:2], 2'b00}, and drop_count SHALL load outstanding - mem_resp_valid.
REQ-026 On redirect_valid, no request SHALL be issued in that cycle, and a response arriving in that cycle SHALL be discarded.
REQ-027 A redirect while drop_count > 0 SHALL apply the same rule as REQ-025, without double counting.
REQ-028 instr_pc SHALL equal the mem_req_addr of the request that produced that entry, tracked by an address FIFO that sits alongside the outstanding counter.
REQ-029 instr_valid SHALL remain asserted, with instr and instr_pc stable, until popped or flushed.

Reset
REQ-030 While rst_n is low at a clk edge, fetch_pc SHALL load PC_INIT, and the buffer, outstanding and drop_count SHALL clear.
REQ-031 From the first cycle after reset, the outputs SHALL be: mem_req_valid 1 (credit available), mem_req_addr PC_INIT, instr_valid 0, instr 0, instr_pc 0.
REQ-032 Memory SHALL share rst_n, and in-flight requests SHALL be discarded on both sides when rst_n is low.

Structure
REQ-033 Shared package fetch_pkg SHALL hold XLEN=32, PC_INIT_DEFAULT, and the fetch_entry_t struct {pc[31:0], instr[31:0]}.
REQ-034 Sub-module fetch_fifo (parameter DEPTH, with push/pop/flush, full/empty and count) SHALL be used for the instruction buffer.
REQ-035 The counter width SHALL be $clog2(DEPTH+1).

Verification
REQ-036 Reset, memory always ready, 1-cycle latency, instr_ready=1 -> instructions appear at PCs 0x8000_0000, _0004, _0008, ... in order, with no duplicates.
REQ-037 instr_ready=0 for 10 cycles -> at most DEPTH requests issued and mem_req_valid drops to 0; release -> stream resumes at the next PC with none lost.
REQ-038 Two requests in flight, then redirect_pc=0x8000_0103 -> both stale responses discarded, next request address 0x8000_0100, next instr_pc 0x8000_0100.
REQ-039 Redirect in the same cycle as mem_resp_valid and instr_ready -> that response dropped, drop_count = outstanding-1, buffer empty next cycle.
REQ-040 Random mem_req_ready and latency 1..5 with random redirects -> every instr_pc matches a scoreboard of expected PCs, and no overflow assertion fires.
REQ-041 fetch_pc at 0xFFFF_FFFC, request accepted -> next mem_req_addr 0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_INIT_DEFAULT = 32'h8000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with flush; the head is read straight from registered storage.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Flush wins over both push and pop in the same cycle.
   always_comb begin
      do_push  = push && !flush;
      do_pop   = pop && !flush && (count_q != '0);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign head_data = empty ? '0 : mem_q[rd_ptr_q];

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited sequential requests, in-order response buffer,
// redirect flush with stale-response dropping.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] PC_INIT = PC_INIT_DEFAULT,
   parameter int unsigned     DEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_resp_valid,
   input  logic [XLEN-1:0] mem_resp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
);

   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W   = CNT_W + 1;
   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

   logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic [CNT_W-1:0]   drop_count_q, drop_count_d;

   logic               accept, live_resp, stale_resp;
   logic               buf_pop, buf_full, buf_empty;
   logic [CNT_W-1:0]   buf_count;
   logic [ENTRY_W-1:0] buf_head;
   fetch_entry_t       push_entry, head_entry;

   logic [XLEN-1:0]    addr_head;
   logic               addr_full, addr_empty;
   logic [CNT_W-1:0]   addr_count;

   // Credit uses registered counts only; a same-cycle pop or response frees nothing yet.
   assign mem_req_valid = ((SUM_W'(buf_count) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH))
                          && !redirect_valid;
   assign mem_req_addr  = fetch_pc_q;

   always_comb begin
      accept        = mem_req_valid && mem_req_ready;
      stale_resp    = mem_resp_valid && (drop_count_q != '0);
      live_resp     = mem_resp_valid && (drop_count_q == '0) && !redirect_valid;
      fetch_pc_d    = fetch_pc_q;
      drop_count_d  = drop_count_q;
      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(mem_resp_valid);
      if (redirect_valid) begin
         fetch_pc_d   = redirect_pc & ~XLEN'(3);
         drop_count_d = outstanding_q - CNT_W'(mem_resp_valid);
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (stale_resp) begin
            drop_count_d = drop_count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q    <= PC_INIT;
         outstanding_q <= '0;
         drop_count_q  <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_count_q  <= drop_count_d;
      end
   end

   // Addresses of live in-flight requests, paired with responses in order.
   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_addr_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (accept),
      .push_data (fetch_pc_q),
      .pop       (live_resp),
      .head_data (addr_head),
      .full      (addr_full),
      .empty     (addr_empty),
      .count     (addr_count)
   );

   assign push_entry = '{pc: addr_head, instr: mem_resp_data};
   assign buf_pop    = instr_valid && instr_ready;

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_instr_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (live_resp),
      .push_data (push_entry),
      .pop       (buf_pop),
      .head_data (buf_head),
      .full      (buf_full),
      .empty     (buf_empty),
      .count     (buf_count)
   );

   assign head_entry  = fetch_entry_t'(buf_head);
   assign instr_valid = !buf_empty;
   assign instr       = head_entry.instr;
   assign instr_pc    = head_entry.pc;

   // Every outstanding request is either stale (drop_count) or tracked by the address FIFO.
   a_track_balance: assert property (@(posedge clk) disable iff (!rst_n)
      (SUM_W'(addr_count) + SUM_W'(drop_count_q)) == SUM_W'(outstanding_q));
   a_buf_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(live_resp && buf_full));
   a_addr_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(accept && addr_full));
   a_addr_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(live_resp && addr_empty));

endmodule
